// File: rtl/frame_tx_if.sv
// frame_tx_if: byte-stream bundle between the two source FIFOs, the arbiter and the shared MAC TX.
interface frame_tx_if;
  logic       a_valid, a_last, a_ready;
  logic       b_valid, b_last, b_ready;
  logic [7:0] a_data, b_data, tx_data;
  logic       tx_ready, tx_valid, tx_last, busy;
  logic [1:0] grant;
  modport master (
    output a_valid, a_data, a_last, b_valid, b_data, b_last, tx_ready,
    input  a_ready, b_ready, tx_valid, tx_data, tx_last, grant, busy
  );
  modport slave (
    input  a_valid, a_data, a_last, b_valid, b_data, b_last, tx_ready,
    output a_ready, b_ready, tx_valid, tx_data, tx_last, grant, busy
  );
endinterface

// File: rtl/frame_tx_arbiter.sv
// frame_tx_arbiter: round-robin merge of two frame byte streams onto one MAC TX port.
// Define ARB_STATS_EN to add saturating frames_a/frames_b/trunc_cnt counters.
module frame_tx_arbiter #(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_LEN    = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  frame_tx_if.slave   bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] frames_a,
  output logic [15:0] frames_b,
  output logic [15:0] trunc_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, SEND, DRAIN, GAP} state_t;
  localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);
  localparam logic [10:0] LEN_LAST = 11'(MAX_LEN - 1);
  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        rr_b_q, rr_b_d;
  logic [10:0] len_q, len_d;
  logic [7:0]  gap_q, gap_d;
  logic        sel_b, src_valid, src_last;
  logic [7:0]  src_data;
  always_comb begin
    sel_b        = grant_q[1];
    src_valid    = sel_b ? bus.b_valid : bus.a_valid;
    src_last     = sel_b ? bus.b_last : bus.a_last;
    src_data     = sel_b ? bus.b_data : bus.a_data;
    state_d      = state_q;
    grant_d      = grant_q;
    rr_b_d       = rr_b_q;
    len_d        = len_q;
    gap_d        = gap_q;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_last  = 1'b0;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
    bus.grant    = 2'b00;
    bus.busy     = state_q != IDLE;
    case (state_q)
      IDLE: if (bus.a_valid || bus.b_valid) begin
        // rr_b_q set means B was served last, so A wins a tie
        grant_d = (bus.a_valid && (!bus.b_valid || rr_b_q)) ? 2'b01 : 2'b10;
        rr_b_d  = grant_d[1];
        len_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        bus.grant    = grant_q;
        bus.tx_valid = src_valid;
        bus.tx_data  = src_data;
        bus.tx_last  = src_valid && (src_last || len_q == LEN_LAST);
        bus.a_ready  = !sel_b && bus.tx_ready;
        bus.b_ready  = sel_b && bus.tx_ready;
        if (src_valid && bus.tx_ready) begin
          len_d   = len_q + 11'd1;
          gap_d   = '0;
          state_d = src_last ? GAP : len_q == LEN_LAST ? DRAIN : SEND;
        end
      end
      DRAIN: begin
        bus.grant   = grant_q;
        bus.a_ready = !sel_b;
        bus.b_ready = sel_b;
        if (src_valid && src_last) begin
          gap_d   = '0;
          state_d = GAP;
        end
      end
      default: begin
        gap_d   = gap_q + 8'd1;
        state_d = gap_q == IFG_LAST ? IDLE : GAP;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      rr_b_q  <= 1'b1;
      len_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_b_q  <= rr_b_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
    end
  end
`ifdef ARB_STATS_EN
  logic [15:0] fa_q, fa_d, fb_q, fb_d, tc_q, tc_d;
  logic        to_gap;
  always_comb begin
    to_gap = state_q != GAP && state_d == GAP;
    fa_d   = fa_q + 16'(to_gap && !sel_b && fa_q != 16'hFFFF);
    fb_d   = fb_q + 16'(to_gap && sel_b && fb_q != 16'hFFFF);
    tc_d   = tc_q + 16'(state_q == SEND && state_d == DRAIN && tc_q != 16'hFFFF);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fa_q <= '0;
      fb_q <= '0;
      tc_q <= '0;
    end else begin
      fa_q <= fa_d;
      fb_q <= fb_d;
      tc_q <= tc_d;
    end
  end
  assign frames_a  = fa_q;
  assign frames_b  = fb_q;
  assign trunc_cnt = tc_q;
`endif
endmodule

// File: tb/tb_frame_tx_arbiter.sv
// tb_frame_tx_arbiter: vector table, directed corner cases and random frames scored
// against a frame-level model (source FIFOs as queues, expected frames by id/length).
module tb_frame_tx_arbiter;
  localparam int IFG  = 12;
  localparam int MAXL = 1518;
  typedef enum {P_IDLE, P_FRAME, P_DRAIN, P_GAP} phase_t;
  typedef struct {
    logic av, al, bv, tr;
    logic [7:0] ad;
    logic [1:0] g;
    logic tv, tl, ar, br, bz;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b1, sel4 = 1'b0;
  logic a_valid_d = 0, a_last_d = 0, b_valid_d = 0, b_last_d = 0, tx_ready_d = 0;
  logic [7:0] a_data_d = 0, b_data_d = 0;
  logic o_valid, o_last, o_ar, o_br, o_busy;
  logic [7:0] o_data;
  logic [1:0] o_grant;
  logic [13:0] outs;
  always #5 clk = ~clk;
  frame_tx_if bus();
  frame_tx_if bus4();
  assign bus.a_valid  = a_valid_d && !sel4;
  assign bus.b_valid  = b_valid_d && !sel4;
  assign bus4.a_valid = a_valid_d && sel4;
  assign bus4.b_valid = b_valid_d && sel4;
  assign bus.a_data   = a_data_d;
  assign bus.b_data   = b_data_d;
  assign bus.a_last   = a_last_d;
  assign bus.b_last   = b_last_d;
  assign bus.tx_ready = tx_ready_d;
  assign bus4.a_data  = a_data_d;
  assign bus4.b_data  = b_data_d;
  assign bus4.a_last  = a_last_d;
  assign bus4.b_last  = b_last_d;
  assign bus4.tx_ready = tx_ready_d;
  assign o_valid = sel4 ? bus4.tx_valid : bus.tx_valid;
  assign o_last  = sel4 ? bus4.tx_last  : bus.tx_last;
  assign o_data  = sel4 ? bus4.tx_data  : bus.tx_data;
  assign o_ar    = sel4 ? bus4.a_ready  : bus.a_ready;
  assign o_br    = sel4 ? bus4.b_ready  : bus.b_ready;
  assign o_busy  = sel4 ? bus4.busy     : bus.busy;
  assign o_grant = sel4 ? bus4.grant    : bus.grant;
  assign outs    = {o_busy, o_grant, o_valid, o_last, o_ar, o_br, o_data};
`ifdef ARB_STATS_EN
  logic [15:0] fa0, fb0, tc0, fa1, fb1, tc1;
`endif
  frame_tx_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef ARB_STATS_EN
    , .frames_a(fa0), .frames_b(fb0), .trunc_cnt(tc0)
`endif
  );
  frame_tx_arbiter #(.IFG_CYCLES(IFG), .MAX_LEN(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4)
`ifdef ARB_STATS_EN
    , .frames_a(fa1), .frames_b(fb1), .trunc_cnt(tc1)
`endif
  );
  int n_chk = 0, n_pass = 0;
  int qa[$], qb[$], ida[$], lena[$], idb[$], lenb[$], glog[$];
  int cnt_fa[2], cnt_fb[2], cnt_tr[2];
  bit last_b[2];
  phase_t ph = P_IDLE;
  int port, fid, flen, expn, k, pops, gapn, drn, next_fid = 0;
  int val_pct = 100, rdy_mode = 0;
  bit prev_idle, pa, pb, hold_a, tog;
  vec_t tbl[6];
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask
  function automatic logic [7:0] dat(input int p, input int f, input int i);
    return 8'(f * 37 + i * 13 + p * 101 + 5);
  endfunction
  task automatic load(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      if (p == 1) qb.push_back(int'(dat(p, next_fid, i)) + (i == n - 1 ? 256 : 0));
      else qa.push_back(int'(dat(p, next_fid, i)) + (i == n - 1 ? 256 : 0));
    end
    if (p == 1) begin idb.push_back(next_fid); lenb.push_back(n); end
    else begin ida.push_back(next_fid); lena.push_back(n); end
    next_fid++;
  endtask
  task automatic sb_reset();
    ph = P_IDLE; prev_idle = 1; pa = 0; pb = 0; hold_a = 0;
    last_b[0] = 1; last_b[1] = 1;
    qa.delete(); qb.delete(); ida.delete(); lena.delete(); idb.delete(); lenb.delete();
    for (int i = 0; i < 2; i++) begin cnt_fa[i] = 0; cnt_fb[i] = 0; cnt_tr[i] = 0; end
  endtask
  task automatic do_reset();
    rst_n = 0; a_valid_d = 0; b_valid_d = 0; tx_ready_d = 0;
    #1 chk("reset_out", int'(outs), 0);
    repeat (2) @(negedge clk);
    sb_reset();
    rst_n = 1;
  endtask
  task automatic enter_gap();
    ph = P_GAP; gapn = 0;
    if (port == 1) cnt_fb[sel4]++; else cnt_fa[sel4]++;
  endtask
  task automatic step();
    int ha, hb, exp_g, maxl;
    bit gv, gl, nidle, pop_a, pop_b;
    @(negedge clk);
    ha = qa.size() > 0 ? qa[0] : 0;
    hb = qb.size() > 0 ? qb[0] : 0;
    a_valid_d = qa.size() > 0 && !hold_a && $urandom_range(99) < val_pct;
    b_valid_d = qb.size() > 0 && $urandom_range(99) < val_pct;
    a_data_d = ha[7:0]; a_last_d = ha[8];
    b_data_d = hb[7:0]; b_last_d = hb[8];
    tog = !tog;
    tx_ready_d = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? tog : ($urandom_range(99) < 70);
    #1;
    maxl = sel4 ? 4 : MAXL;
    nidle = 0;
    if (ph == P_IDLE) begin
      exp_g = !prev_idle ? 0 : (pa && pb) ? (last_b[sel4] ? 1 : 2) : pa ? 1 : pb ? 2 : 0;
      chk("idle_grant", int'(o_grant), exp_g);
      if (o_grant != 2'b00) begin
        port = o_grant == 2'b10 ? 1 : 0;
        last_b[sel4] = port[0];
        glog.push_back(int'(o_grant));
        if (port == 1 && idb.size() > 0) begin fid = idb.pop_front(); flen = lenb.pop_front(); end
        else if (port == 0 && ida.size() > 0) begin fid = ida.pop_front(); flen = lena.pop_front(); end
        else begin fid = 0; flen = 1; end
        expn = flen < maxl ? flen : maxl;
        k = 0; pops = 0; ph = P_FRAME;
      end else begin
        chk("idle_out", int'({o_busy, o_valid, o_last, o_ar, o_br}), 0);
        nidle = 1;
      end
    end
    gv = port == 1 ? b_valid_d : a_valid_d;
    gl = port == 1 ? b_last_d : a_last_d;
    if (ph == P_FRAME) begin
      chk("grant_hold", int'(o_grant), port == 1 ? 2 : 1);
      chk("tx_valid", int'(o_valid), int'(gv));
      chk("ready", int'({o_br, o_ar}), tx_ready_d ? (port == 1 ? 2 : 1) : 0);
      if (!o_valid) chk("last_idle", int'(o_last), 0);
      if (gv && tx_ready_d) begin
        chk("tx_data", int'(o_data), int'(dat(port, fid, k)));
        chk("tx_last", int'(o_last), int'(k == expn - 1));
        k++;
        if (k == expn && expn < flen) begin ph = P_DRAIN; drn = 0; cnt_tr[sel4]++; end
        else if (k == expn) enter_gap();
      end
    end else if (ph == P_DRAIN) begin
      chk("drain_grant", int'(o_grant), port == 1 ? 2 : 1);
      chk("drain_out", int'({o_valid, o_last, o_br, o_ar}), port == 1 ? 2 : 1);
      drn++;
      if (gv && gl) enter_gap();
    end else if (ph == P_GAP) begin
      chk("gap_out", int'({o_busy, o_grant, o_valid, o_last, o_ar, o_br}), 64);
      gapn++;
      if (gapn == IFG) begin
        chk("src_pops", pops, flen);
        ph = P_IDLE;
      end
    end
    pop_a = o_ar && a_valid_d;
    pop_b = o_br && b_valid_d;
    if (pop_a && qa.size() > 0) void'(qa.pop_front());
    if (pop_b && qb.size() > 0) void'(qb.pop_front());
    if ((port == 0 && pop_a) || (port == 1 && pop_b)) pops++;
    pa = a_valid_d; pb = b_valid_d; prev_idle = nidle;
  endtask
  task automatic run_done(input int budget);
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || ph != P_IDLE) && n < budget) begin
      step();
      n++;
    end
    chk("done_in_budget", int'(n < budget), 1);
  endtask
  initial begin
    tbl[0] = '{1, 0, 1, 1, 8'h11, 2'b00, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 1, 0, 8'h22, 2'b01, 1, 0, 0, 0, 1};
    tbl[2] = '{1, 0, 1, 1, 8'h33, 2'b01, 1, 0, 1, 0, 1};
    tbl[3] = '{0, 0, 1, 1, 8'h44, 2'b01, 0, 0, 1, 0, 1};
    tbl[4] = '{1, 1, 1, 1, 8'h55, 2'b01, 1, 1, 1, 0, 1};
    tbl[5] = '{1, 0, 1, 1, 8'h66, 2'b00, 0, 0, 0, 0, 1};
    sb_reset();
    #1 do_reset();
    sel4 = 1;
    #1 chk("reset_out_dut4", int'(outs), 0);
    sel4 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a_valid_d = tbl[i].av; a_last_d = tbl[i].al; a_data_d = tbl[i].ad;
      b_valid_d = tbl[i].bv; b_last_d = 0; b_data_d = 8'hEE; tx_ready_d = tbl[i].tr;
      #1;
      chk($sformatf("vec%0d", i), int'({o_grant, o_valid, o_last, o_ar, o_br, o_busy}),
          int'({tbl[i].g, tbl[i].tv, tbl[i].tl, tbl[i].ar, tbl[i].br, tbl[i].bz}));
      if (tbl[i].tv) chk($sformatf("vec%0d_data", i), int'(o_data), int'(tbl[i].ad));
    end
    do_reset();
    load(0, 3); load(1, 3); glog.delete();
    run_done(200);
    chk("tie_count", glog.size(), 2);
    chk("tie_first_a", glog[0], 1);
    chk("tie_then_b", glog[1], 2);
    rdy_mode = 1;
    load(0, 64);
    run_done(400);
    rdy_mode = 0;
    load(0, 20);
    repeat (8) step();
    hold_a = 1;
    repeat (5) begin
      step();
      chk("stall_state", int'({o_busy, o_grant, o_valid}), 4'b1010);
    end
    hold_a = 0;
    run_done(200);
    do_reset();
    for (int i = 0; i < 3; i++) begin load(0, 5 + i); load(1, 4 + i); end
    glog.delete();
    run_done(500);
    chk("b2b_count", glog.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("b2b_grant%0d", i), glog[i], i % 2 == 0 ? 1 : 2);
    load(0, 10);
    for (int n = 0; n < 50 && !(ph == P_FRAME && k == 1); n++) step();
    @(negedge clk);
    #1 chk("pre_reset_busy", int'(o_busy), 1);
    rst_n = 0;
    #1 chk("reset_midframe", int'(outs), 0);
    do_reset();
    load(0, 10); glog.delete();
    run_done(200);
    chk("restart_grant", glog.size() > 0 ? glog[0] : 0, 1);
    do_reset();
    sel4 = 1;
    load(1, 7);
    run_done(200);
    chk("trunc_drain_cycles", drn, 3);
    chk("trunc_count_model", cnt_tr[1], 1);
`ifdef ARB_STATS_EN
    chk("trunc_cnt", int'(tc1), 1);
    chk("frames_b4", int'(fb1), 1);
`endif
    for (int r = 0; r < 8; r++) begin
      sel4 = r[0];
      val_pct = $urandom_range(100, 40);
      rdy_mode = $urandom_range(2, 1);
      for (int f = 0; f < 6; f++) load($urandom_range(1, 0), $urandom_range(sel4 ? 10 : 40, 1));
      run_done(5000);
    end
`ifdef ARB_STATS_EN
    chk("frames_a0", int'(fa0), cnt_fa[0]);
    chk("frames_b0", int'(fb0), cnt_fb[0]);
    chk("trunc0", int'(tc0), cnt_tr[0]);
    chk("frames_a1", int'(fa1), cnt_fa[1]);
    chk("frames_b1", int'(fb1), cnt_fb[1]);
    chk("trunc1", int'(tc1), cnt_tr[1]);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/frame_tx_arbiter.md
FRAME_TX_ARBITER -- requirements
Module: frame_tx_arbiter

Interface
REQ-001 Parameter IFG_CYCLES, default 12, idle cycles inserted after every frame end (legal range 1..255).
REQ-002 Parameter MAX_LEN, default 1518, maximum bytes forwarded per frame (legal range 2..2047).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 a_valid / a_data / a_last  input  1/8/1  port A byte stream from its FIFO: byte present, data, end of frame.
REQ-006 a_ready  output  1  port A byte consumed this cycle (FIFO read strobe).
REQ-007 b_valid / b_data / b_last / b_ready  in/in/in/out  1/8/1/1  port B, identical semantics.
REQ-008 tx_ready  input  1  MAC accepts byte this cycle.
REQ-009 tx_valid / tx_data / tx_last  output  1/8/1  byte stream to shared MAC TX.
REQ-010 grant  output  2  one-hot current owner ({B,A}); 2'b00 when no owner.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, SEND, DRAIN, GAP; exactly one is active.
REQ-013 IDLE: if only one of a_valid/b_valid is high, grant that port; if both are high, grant the port not served last (round-robin pointer); go to SEND next cycle.
REQ-014 Grant and the round-robin pointer SHALL change only on the IDLE->SEND transition; the pointer records the granted port.
REQ-015 SEND: tx_valid = granted valid, tx_data = granted data, a_ready/b_ready = tx_ready for the granted port only, zero-cycle combinational path.
REQ-016 Ungranted port ready SHALL be 0 in every state.
REQ-017 A transfer occurs when tx_valid and tx_ready are both high; the 11-bit length counter increments per transfer and clears on entering SEND.
REQ-018 Transfer with source last high SHALL assert tx_last and move SEND->GAP.
REQ-019 Transfer with length counter == MAX_LEN-1 and source last low SHALL force tx_last high and move SEND->DRAIN (truncation).
REQ-020 DRAIN: tx_valid = 0; granted ready = 1; discard bytes until a byte with source last is consumed, then go to GAP.
REQ-021 GAP: tx_valid = 0, grant = 2'b00, all ready signals 0; 8-bit counter runs IFG_CYCLES cycles, then IDLE.
REQ-022 Source valid dropping mid-frame in SEND SHALL stall without ending the frame; tx_valid follows the source.
REQ-023 tx_ready low in SEND SHALL hold tx_data/tx_last stable with respect to the source, with no counter change.
REQ-024 tx_last SHALL be 0 whenever tx_valid is 0.

Reset
REQ-025 On rst_n low, regardless of state or frame in progress: state IDLE, grant 2'b00, round-robin pointer = B (so A wins the first tie), counters 0, tx_valid/tx_last/a_ready/b_ready/busy 0, tx_data 8'h00.
REQ-026 A frame interrupted by reset SHALL NOT be resumed; after release the arbiter restarts in IDLE.

Configuration
REQ-027 Macro ARB_STATS_EN defined: outputs frames_a, frames_b, trunc_cnt (16 bits each) exist; frames_x increments when a frame granted to port x enters GAP; trunc_cnt increments on each SEND->DRAIN; all saturate at 16'hFFFF and reset to 0.
REQ-028 ARB_STATS_EN undefined: those ports and counters are absent; all other behaviour is identical.

Verification
REQ-029 After reset, a_valid and b_valid both high with 3-byte frames -> A frame sent first (grant 2'b01), 12 GAP cycles, then B frame (grant 2'b10).
REQ-030 Port A only, 64-byte frame, tx_ready toggled 1010... -> 64 transfers in order, tx_last on byte 64 only, a_ready never high while tx_ready is low.
REQ-031 MAX_LEN=4, port B frame of 7 bytes -> 4 bytes on TX with tx_last on byte 4; 3 bytes drained (b_ready=1, tx_valid=0); then GAP; trunc_cnt=1 when ARB_STATS_EN is defined.
REQ-032 rst_n pulsed low during byte 2 of a frame -> all outputs 0 in the same cycle; after release with a_valid=1, SEND restarts in IDLE with length 0.
REQ-033 a_valid low for 5 cycles mid-frame -> tx_valid low for those 5 cycles, state stays SEND, frame completes with one tx_last.
REQ-034 Three back-to-back frames on both ports -> grants alternate A,B,A,B,A,B with exactly IFG_CYCLES idle cycles between frames.
